// File: rtl/filter_pkg.sv
// Shared widths and FSM encoding for the filter input-side MAC datapath.
package filter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int PROD_W     = DATA_W_DEF + COEF_W_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/filter_delay_line.sv
// Circular sample buffer with auto-incrementing write pointer, one-cycle flush,
// and a registered read at offset k behind the most recently written sample.
module filter_delay_line #(
  parameter int NUM_TAPS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     flush,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_k,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [NUM_TAPS];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        n_ptr;
  logic [ADDR_W-1:0]        rd_idx;

  // ADDR_W-bit subtraction gives the modulo-NUM_TAPS wrap for free
  assign rd_idx = n_ptr - rd_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
      wr_ptr <= '0;
      n_ptr  <= '0;
      rdata  <= '0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
        wr_ptr <= '0;
      end else if (we) begin
        mem[wr_ptr] <= wdata;
        n_ptr       <= wr_ptr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rdata <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/filter_mac_accumulator.sv
// Sequential single-multiplier FIR MAC: one sample in, T taps walked, one
// 40-bit result out with a one-cycle acc_valid strobe.
module filter_mac_accumulator
  import filter_pkg::*;
#(
  parameter int NUM_TAPS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     trig_flush,
  input  logic [ADDR_W:0]          rf_num_taps,
  output logic                     coef_rd_en,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  output logic                     busy
);

  // Equals DATA_W+COEF_W, anchored to the package default width
  localparam int PW = PROD_W + (DATA_W - DATA_W_DEF) + (COEF_W - COEF_W_DEF);

  logic [1:0]               state;
  logic [ADDR_W:0]          t_cnt;
  logic [ADDR_W:0]          t_sel;
  logic [ADDR_W-1:0]        k;
  logic                     accept;
  logic                     issue;
  logic                     last_issue;
  logic                     acc_en;
  logic signed [DATA_W-1:0] x;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;

  assign sample_ready = (state == ST_IDLE) && !trig_flush;
  assign accept       = sample_valid && sample_ready;
  assign issue        = (state == ST_MAC);
  assign coef_rd_en   = issue;
  assign coef_addr    = k;
  assign busy         = (state != ST_IDLE);
  assign acc_valid    = (state == ST_DONE);

  assign t_sel = (rf_num_taps == '0 || rf_num_taps > (ADDR_W+1)'(NUM_TAPS))
               ? (ADDR_W+1)'(NUM_TAPS) : rf_num_taps;
  assign last_issue = ({1'b0, k} == t_cnt - 1'b1);

  assign prod     = $signed(coef_data) * x;
  assign acc_next = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

  filter_delay_line #(
    .NUM_TAPS (NUM_TAPS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .wdata (sample_in),
    .flush (trig_flush && (state == ST_IDLE)),
    .rd_en (issue),
    .rd_k  (k),
    .rdata (x)
  );

  // coef_data and x both arrive one cycle after issue, so accumulation lags by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      t_cnt   <= '0;
      k       <= '0;
      acc     <= '0;
      acc_out <= '0;
      acc_en  <= 1'b0;
    end else begin
      acc_en <= issue;
      if (acc_en) acc <= acc_next;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            t_cnt <= t_sel;
            acc   <= '0;
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          k <= k + 1'b1;
          if (last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          acc_out <= acc_next;
          k       <= '0;
          state   <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_mac_accumulator.sv
// Directed bench for filter_mac_accumulator with a one-cycle-latency coefficient ROM model.
module tb_filter_mac_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;
  logic               trig_flush;
  logic [4:0]         rf_num_taps;
  logic               coef_rd_en;
  logic [3:0]         coef_addr;
  logic [15:0]        coef_data;
  logic signed [39:0] acc_out;
  logic               acc_valid;
  logic               busy;

  logic [15:0] coef_mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (coef_rd_en) coef_data <= coef_mem[coef_addr];

  filter_mac_accumulator #(
    .NUM_TAPS (16),
    .ADDR_W   (4),
    .DATA_W   (16),
    .COEF_W   (16),
    .ACC_W    (40)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .trig_flush   (trig_flush),
    .rf_num_taps  (rf_num_taps),
    .coef_rd_en   (coef_rd_en),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .acc_out      (acc_out),
    .acc_valid    (acc_valid),
    .busy         (busy)
  );

  task automatic set_coefs(input logic [15:0] v);
    for (int i = 0; i < 16; i++) coef_mem[i] = v;
  endtask

  task automatic do_flush();
    @(negedge clk);
    trig_flush = 1'b1;
    @(negedge clk);
    trig_flush = 1'b0;
  endtask

  // Feeds one sample; returns result, accept-to-valid latency (-1 on timeout)
  // and strobe width (1 or 2 cycles observed).
  task automatic do_sample(input logic signed [15:0] s, input logic [4:0] rf,
                           input logic [4:0] rf_after, output logic signed [39:0] res,
                           output int lat, output int width);
    @(negedge clk);
    sample_in    = s;
    sample_valid = 1'b1;
    rf_num_taps  = rf;
    for (int i = 0; i < 50 && !sample_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    rf_num_taps  = rf_after;
    lat   = -1;
    width = 0;
    res   = '0;
    for (int c = 1; c <= 60; c++) begin
      if (acc_valid) begin
        lat = c;
        res = acc_out;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      width = acc_valid ? 2 : 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample_in = '0; sample_valid = 1'b0; trig_flush = 1'b0; rf_num_taps = 5'd4;
    set_coefs(16'd0);
    repeat (2) @(negedge clk);
    n_cmp++; if (acc_out !== 40'sd0) begin n_bad++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_acc_valid got %b want 0", acc_valid); end
    n_cmp++; if (coef_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_coef_rd_en got %b want 0", coef_rd_en); end
    n_cmp++; if (coef_addr !== 4'd0) begin n_bad++; $display("FAIL reset_coef_addr got %0d want 0", coef_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", sample_ready); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] smp [5];
    logic signed [39:0] exp_v [5];
    logic signed [39:0] res;
    int lat, width;
    smp = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    exp_v = '{40'sd1, 40'sd2, 40'sd3, 40'sd4, 40'sd0};
    for (int i = 0; i < 4; i++) coef_mem[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) begin
      do_sample(smp[i], 5'd4, 5'd4, res, lat, width);
      n_cmp++; if (res !== exp_v[i]) begin n_bad++; $display("FAIL impulse_out[%0d] got %0d want %0d", i, res, exp_v[i]); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL impulse_latency[%0d] got %0d want 6", i, lat); end
      n_cmp++; if (width !== 1) begin n_bad++; $display("FAIL impulse_strobe_width[%0d] got %0d want 1", i, width); end
    end
    n_cmp++; if (acc_out !== 40'sd0) begin n_bad++; $display("FAIL impulse_hold got %0d want 0", acc_out); end
  endtask

  task automatic test_magnitude();
    logic signed [39:0] res;
    longint exp_l;
    int lat, width;
    do_flush();
    set_coefs(16'h8000);
    for (int i = 1; i <= 16; i++) begin
      do_sample(-16'sd32768, 5'd16, 5'd16, res, lat, width);
      exp_l = longint'(i) * 64'sd1073741824;
      n_cmp++; if (res !== exp_l[39:0]) begin n_bad++; $display("FAIL magnitude_out[%0d] got %0d want %0d", i, res, exp_l); end
    end
    n_cmp++; if (acc_out !== 40'sh04_0000_0000) begin n_bad++; $display("FAIL magnitude_final got %h want 0400000000", acc_out); end
  endtask

  task automatic test_wrap();
    logic signed [39:0] res;
    longint exp_l;
    int lat, width;
    do_flush();
    set_coefs(16'd1);
    for (int i = 1; i <= 20; i++) begin
      do_sample(16'(i), 5'd16, 5'd16, res, lat, width);
      exp_l = 0;
      for (int j = (i > 16 ? i - 15 : 1); j <= i; j++) exp_l += j;
      if (i >= 15) begin
        n_cmp++; if (res !== exp_l[39:0]) begin n_bad++; $display("FAIL wrap_out[%0d] got %0d want %0d", i, res, exp_l); end
      end
    end
    n_cmp++; if (res !== 40'sd200) begin n_bad++; $display("FAIL wrap_final got %0d want 200", res); end
  endtask

  task automatic test_flush_collision();
    logic signed [39:0] res;
    int lat, width;
    set_coefs(16'd1);
    for (int i = 0; i < 16; i++) do_sample(16'sd7, 5'd16, 5'd16, res, lat, width);
    n_cmp++; if (res !== 40'sd112) begin n_bad++; $display("FAIL flush_fill got %0d want 112", res); end
    @(negedge clk);
    trig_flush = 1'b1; sample_valid = 1'b1; sample_in = 16'sd99; rf_num_taps = 5'd4;
    #1;
    n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", sample_ready); end
    @(negedge clk);
    trig_flush = 1'b0; sample_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept busy got %b want 0", busy); end
    do_sample(16'sd1, 5'd4, 5'd4, res, lat, width);
    n_cmp++; if (res !== 40'sd1) begin n_bad++; $display("FAIL flush_after got %0d want 1", res); end
  endtask

  task automatic test_clamp();
    logic signed [39:0] res;
    int lat, width;
    // delay line holds 1 at slot 0 from the flush test
    do_sample(16'sd2, 5'd0, 5'd0, res, lat, width);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL clamp_zero_latency got %0d want 18", lat); end
    n_cmp++; if (res !== 40'sd3) begin n_bad++; $display("FAIL clamp_zero_out got %0d want 3", res); end
    do_sample(16'sd3, 5'd31, 5'd31, res, lat, width);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL clamp_31_latency got %0d want 18", lat); end
    n_cmp++; if (res !== 40'sd6) begin n_bad++; $display("FAIL clamp_31_out got %0d want 6", res); end
    do_sample(16'sd4, 5'd2, 5'd16, res, lat, width);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL clamp_midmac_latency got %0d want 4", lat); end
    n_cmp++; if (res !== 40'sd7) begin n_bad++; $display("FAIL clamp_midmac_out got %0d want 7", res); end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [39:0] res;
    int lat, width;
    int seen;
    @(negedge clk);
    sample_in = 16'sd5; sample_valid = 1'b1; rf_num_taps = 5'd16;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (acc_out !== 40'sd0) begin n_bad++; $display("FAIL rst_mid_acc_out got %0d want 0", acc_out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (acc_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_valid got %0d strobes want 0", seen); end
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b want 1", sample_ready); end
    n_cmp++; if (acc_out !== 40'sd0) begin n_bad++; $display("FAIL rst_mid_acc_after got %0d want 0", acc_out); end
    do_sample(16'sd1, 5'd16, 5'd16, res, lat, width);
    n_cmp++; if (res !== 40'sd1) begin n_bad++; $display("FAIL rst_mid_delay_zeroed got %0d want 1", res); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_magnitude();
    test_wrap();
    test_flush_collision();
    test_clamp();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
